// File: rtl/aurora_seq_pkg.sv
// Shared state encoding, status-bus/CSR bit positions and output decode for the Aurora link sequencer.
package aurora_seq_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RST_LEAD  = 3'd1,
      PMA_HOLD  = 3'd2,
      RST_TRAIL = 3'd3,
      WAIT_UP   = 3'd4,
      UP        = 3'd5,
      RETRY     = 3'd6,
      FAULT     = 3'd7
   } seqState_e;

   // Synchronised status bus layout (bit positions within the sync_2ff bus)
   localparam int STATUS_WIDTH  = 4;
   localparam int SYNC_CH_UP    = 0;
   localparam int SYNC_LANE_UP  = 1;
   localparam int SYNC_HARD_ERR = 2;
   localparam int SYNC_MMCM     = 3;

   localparam int CSR_STATE_LSB   = 0;
   localparam int CSR_LINK_UP_BIT = 3;
   localparam int CSR_FAULT_BIT   = 4;
   localparam int CSR_RETRY_LSB   = 5;
   localparam int CSR_WIDTH       = 9;

   typedef struct packed {
      logic mgtReset;
      logic pmaInit;
      logic linkUp;
      logic fault;
   } seqOut_t;

   function automatic seqOut_t decodeOutputs(seqState_e s);
      seqOut_t o;
      o = '{mgtReset: 1'b1, pmaInit: 1'b0, linkUp: 1'b0, fault: 1'b0};
      case (s)
         IDLE, PMA_HOLD: o.pmaInit = 1'b1;
         WAIT_UP:        o.mgtReset = 1'b0;
         UP:             begin o.mgtReset = 1'b0; o.linkUp = 1'b1; end
         FAULT:          begin o.pmaInit = 1'b1; o.fault = 1'b1; end
         default:        ;
      endcase
      return o;
   endfunction

   function automatic logic [CSR_WIDTH-1:0] packStatus(seqState_e s, logic linkUp, logic fault,
                                                       logic [3:0] retryCount);
      return {retryCount, fault, linkUp, s};
   endfunction

endpackage

// File: rtl/aurora_link_sequencer_sync_2ff.sv
// Parameterised-width two-flop synchroniser with a per-bit reset value.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stable;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= RESET_VAL;
         stable <= RESET_VAL;
      end else begin
         meta   <= d;
         stable <= meta;
      end
   end

   assign q = stable;

endmodule

// File: rtl/aurora_link_sequencer.sv
// Aurora 64b66b bring-up/recovery sequencer in the sysClk domain.
// Optional soft-error counter enabled by defining AURORA_SEQ_ERR_COUNT_EN.
module aurora_link_sequencer
   import aurora_seq_pkg::*;
#(
   parameter int PMA_INIT_CYCLES    = 1024,
   parameter int RESET_LEAD_CYCLES  = 128,
   parameter int CHANNEL_UP_TIMEOUT = 65536,
   parameter int HOLDOFF_CYCLES     = 4096,
   parameter int MAX_RETRIES        = 7,
   parameter int CNT_WIDTH          = 24
) (
   input  logic        sysClk,
   input  logic        sysReset,
   input  logic        enable,
   input  logic        restartStrobe,
   input  logic        channelUp,
   input  logic        laneUp,
   input  logic        hardErr,
   input  logic        mmcmNotLocked,
`ifdef AURORA_SEQ_ERR_COUNT_EN
   input  logic        softErr,
   output logic [15:0] errCount,
`endif
   output logic        mgtReset,
   output logic        pmaInit,
   output logic        linkUp,
   output logic        fault,
   output logic [2:0]  state,
   output logic [3:0]  retryCount
);

`ifdef AURORA_SEQ_ERR_COUNT_EN
   localparam int SYNC_SOFT_ERR = STATUS_WIDTH;
   localparam int SYNC_W        = STATUS_WIDTH + 1;
`else
   localparam int SYNC_W        = STATUS_WIDTH;
`endif
   localparam logic [SYNC_W-1:0] SYNC_RESET = SYNC_W'(1) << SYNC_MMCM;

   localparam logic [CNT_WIDTH-1:0] LEAD_LAST    = CNT_WIDTH'(RESET_LEAD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] PMA_LAST     = CNT_WIDTH'(PMA_INIT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(CHANNEL_UP_TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] HOLDOFF_LAST = CNT_WIDTH'(HOLDOFF_CYCLES - 1);

   logic [SYNC_W-1:0]    rawStatus;
   logic [SYNC_W-1:0]    syncStatus;
   seqState_e            curState;
   seqState_e            nextState;
   seqOut_t              nextOut;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 restartHit;
   logic                 clearRetry;
   logic                 bumpRetry;
   logic                 timed;
   logic                 chUpSync;
   logic                 laneUpSync;
   logic                 hardErrSync;
   logic                 mmcmSync;

`ifdef AURORA_SEQ_ERR_COUNT_EN
   assign rawStatus = {softErr, mmcmNotLocked, hardErr, laneUp, channelUp};
`else
   assign rawStatus = {mmcmNotLocked, hardErr, laneUp, channelUp};
`endif

   sync_2ff #(.WIDTH(SYNC_W), .RESET_VAL(SYNC_RESET)) statusSync (
      .clk (sysClk),
      .rst (sysReset),
      .d   (rawStatus),
      .q   (syncStatus)
   );

   assign chUpSync    = syncStatus[SYNC_CH_UP];
   assign laneUpSync  = syncStatus[SYNC_LANE_UP];
   assign hardErrSync = syncStatus[SYNC_HARD_ERR];
   assign mmcmSync    = syncStatus[SYNC_MMCM];

   always_comb begin
      nextState  = curState;
      restartHit = 1'b0;
      clearRetry = 1'b0;
      if (!enable) begin
         nextState = IDLE;
      end else if (restartStrobe) begin
         nextState  = RST_LEAD;
         restartHit = 1'b1;
         clearRetry = 1'b1;
      end else begin
         case (curState)
            IDLE:      nextState = RST_LEAD;
            RST_LEAD:  if (cnt == LEAD_LAST) nextState = PMA_HOLD;
            PMA_HOLD:  if (cnt == PMA_LAST) nextState = RST_TRAIL;
            // Lead time must have elapsed and the MMCM must be locked before releasing reset
            RST_TRAIL: if (cnt >= LEAD_LAST && !mmcmSync) nextState = WAIT_UP;
            WAIT_UP: begin
               if (hardErrSync) begin
                  nextState = RETRY;
               end else if (chUpSync && laneUpSync) begin
                  nextState  = UP;
                  clearRetry = 1'b1;
               end else if (cnt == TIMEOUT_LAST) begin
                  nextState = RETRY;
               end
            end
            UP:        if (!chUpSync || hardErrSync || mmcmSync) nextState = RETRY;
            RETRY: begin
               if (MAX_RETRIES != 0 && int'(retryCount) >= MAX_RETRIES) nextState = FAULT;
               else if (cnt == HOLDOFF_LAST) nextState = RST_LEAD;
            end
            FAULT:     nextState = FAULT;
            default:   nextState = IDLE;
         endcase
      end
   end

   assign bumpRetry = (nextState == RETRY) && (curState != RETRY);
   assign timed     = curState inside {RST_LEAD, PMA_HOLD, RST_TRAIL, WAIT_UP, RETRY};
   assign nextOut   = decodeOutputs(nextState);

   // Outputs are registered from the next state so they always match the state register
   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         curState   <= IDLE;
         cnt        <= '0;
         retryCount <= '0;
         mgtReset   <= 1'b1;
         pmaInit    <= 1'b1;
         linkUp     <= 1'b0;
         fault      <= 1'b0;
      end else begin
         curState <= nextState;
         if (restartHit || nextState != curState) cnt <= '0;
         else if (timed && cnt != '1)             cnt <= cnt + 1'b1;
         if (clearRetry)                            retryCount <= '0;
         else if (bumpRetry && retryCount != 4'hF)  retryCount <= retryCount + 1'b1;
         {mgtReset, pmaInit, linkUp, fault} <= nextOut;
      end
   end

   assign state = curState;

`ifdef AURORA_SEQ_ERR_COUNT_EN
   logic softPrev;

   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         softPrev <= 1'b0;
         errCount <= '0;
      end else begin
         softPrev <= syncStatus[SYNC_SOFT_ERR];
         if (nextState == RST_LEAD && (curState != RST_LEAD || restartHit))
            errCount <= '0;
         else if (curState == UP && syncStatus[SYNC_SOFT_ERR] && !softPrev && errCount != 16'hFFFF)
            errCount <= errCount + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Directed/randomised bench for aurora_link_sequencer; expectations come from phase lengths and sync latency.
module tb_aurora_link_sequencer;

   localparam int PMA_N   = 16;
   localparam int LEAD_N  = 4;
   localparam int TOUT_N  = 32;
   localparam int HOLD_N  = 8;
   localparam int MAXR    = 2;
   localparam int SYNC_LAT = 3;

   logic       sysClk;
   logic       sysReset;
   logic       enable;
   logic       restartStrobe;
   logic       channelUp;
   logic       laneUp;
   logic       hardErr;
   logic       mmcmNotLocked;
   logic       mgtReset;
   logic       pmaInit;
   logic       linkUp;
   logic       fault;
   logic [2:0] state;
   logic [3:0] retryCount;
`ifdef AURORA_SEQ_ERR_COUNT_EN
   logic        softErr;
   logic [15:0] errCount;
`endif

   int total = 0;
   int bad   = 0;
   int len;
   int lat;
   int d;
   int h;

   aurora_link_sequencer #(
      .PMA_INIT_CYCLES    (PMA_N),
      .RESET_LEAD_CYCLES  (LEAD_N),
      .CHANNEL_UP_TIMEOUT (TOUT_N),
      .HOLDOFF_CYCLES     (HOLD_N),
      .MAX_RETRIES        (MAXR),
      .CNT_WIDTH          (24)
   ) dut (
      .sysClk        (sysClk),
      .sysReset      (sysReset),
      .enable        (enable),
      .restartStrobe (restartStrobe),
      .channelUp     (channelUp),
      .laneUp        (laneUp),
      .hardErr       (hardErr),
      .mmcmNotLocked (mmcmNotLocked),
`ifdef AURORA_SEQ_ERR_COUNT_EN
      .softErr       (softErr),
      .errCount      (errCount),
`endif
      .mgtReset      (mgtReset),
      .pmaInit       (pmaInit),
      .linkUp        (linkUp),
      .fault         (fault),
      .state         (state),
      .retryCount    (retryCount)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   task automatic tick();
      @(posedge sysClk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Count ticks spent in state st, starting from a tick where the DUT is already in st
   task automatic measure(input int st, output int n);
      n = 0;
      while (int'(state) == st && n < 500) begin
         n++;
         tick();
      end
   endtask

   task automatic waitLink(input logic level, output int n);
      n = 0;
      while (linkUp !== level && n < 100) begin
         tick();
         n++;
      end
   endtask

   always @(negedge sysClk)
      check("pmaWithoutMgtReset", int'(pmaInit && !mgtReset), 0);

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sysReset = 1'b1; enable = 1'b0; restartStrobe = 1'b0;
      channelUp = 1'b0; laneUp = 1'b0; hardErr = 1'b0; mmcmNotLocked = 1'b0;
`ifdef AURORA_SEQ_ERR_COUNT_EN
      softErr = 1'b0;
`endif
      repeat (3) tick();
      check("rstState", int'(state), 0);
      check("rstMgtReset", int'(mgtReset), 1);
      check("rstPmaInit", int'(pmaInit), 1);
      check("rstLinkUp", int'(linkUp), 0);
      check("rstFault", int'(fault), 0);
      check("rstRetry", int'(retryCount), 0);

      sysReset = 1'b0;
      tick();
      check("idleHold", int'(state), 0);
      restartStrobe = 1'b1; tick(); restartStrobe = 1'b0; tick();
      check("strobeIgnoredDisabled", int'(state), 0);

      // Nominal bring-up
      enable = 1'b1;
      tick();
      check("leadState", int'(state), 1);
      check("leadMgt", int'(mgtReset), 1);
      check("leadPma", int'(pmaInit), 0);
      measure(1, len);
      check("leadLen", len, LEAD_N);
      check("holdState", int'(state), 2);
      check("holdPma", int'(pmaInit), 1);
      measure(2, len);
      check("holdLen", len, PMA_N);
      check("trailPma", int'(pmaInit), 0);
      measure(3, len);
      check("trailLen", len, LEAD_N);
      check("waitState", int'(state), 4);
      check("waitMgt", int'(mgtReset), 0);
      d = int'($urandom_range(5, 20));
      repeat (d) tick();
      check("waitStill", int'(state), 4);
      channelUp = 1'b1; laneUp = 1'b1;
      waitLink(1'b1, lat);
      check("upLatency", lat, SYNC_LAT);
      check("upState", int'(state), 5);
      check("upRetry", int'(retryCount), 0);
      check("upMgt", int'(mgtReset), 0);

      // Link loss by a one-cycle hardErr pulse
      repeat (int'($urandom_range(2, 10))) tick();
      hardErr = 1'b1; tick(); hardErr = 1'b0;
      lat = 1;
      while (linkUp === 1'b1 && lat < 50) begin tick(); lat++; end
      check("lossLatency", lat, SYNC_LAT);
      check("lossState", int'(state), 6);
      check("lossRetry", int'(retryCount), 1);
      check("lossMgt", int'(mgtReset), 1);
      check("lossPma", int'(pmaInit), 0);
      measure(6, len);
      check("holdoffLen", len, HOLD_N);
      check("reLeadState", int'(state), 1);
      measure(1, len); measure(2, len); measure(3, len);
      check("reWaitState", int'(state), 4);
      tick();
      check("reUpState", int'(state), 5);
      check("reUpRetryCleared", int'(retryCount), 0);

      // Channel drop, then a timeout that exhausts the retry budget
      channelUp = 1'b0; laneUp = 1'b0;
      waitLink(1'b0, lat);
      check("dropLatency", lat, SYNC_LAT);
      check("dropRetry", int'(retryCount), 1);
      measure(6, len);
      check("dropHoldoff", len, HOLD_N);
      measure(1, len); measure(2, len); measure(3, len);
      measure(4, len);
      check("timeoutLen", len, TOUT_N);
      check("timeoutState", int'(state), 6);
      check("timeoutRetry", int'(retryCount), MAXR);
      measure(6, len);
      check("retryToFaultLen", len, 1);
      check("faultState", int'(state), 7);
      check("faultFlag", int'(fault), 1);
      check("faultMgt", int'(mgtReset), 1);
      check("faultPma", int'(pmaInit), 1);
      check("faultLink", int'(linkUp), 0);
      repeat (int'($urandom_range(3, 30))) tick();
      check("faultSticky", int'(state), 7);
      restartStrobe = 1'b1; tick(); restartStrobe = 1'b0;
      check("restartState", int'(state), 1);
      check("restartRetry", int'(retryCount), 0);
      check("restartFault", int'(fault), 0);

      // Single timeout retry
      measure(1, len); measure(2, len); measure(3, len);
      measure(4, len);
      check("timeout1Len", len, TOUT_N);
      check("timeout1State", int'(state), 6);
      check("timeout1Retry", int'(retryCount), 1);
      measure(6, len);
      check("timeout1Holdoff", len, HOLD_N);
      check("timeout1Lead", int'(state), 1);

      // enable dropped mid PMA_HOLD
      measure(1, len);
      repeat (int'($urandom_range(1, 14))) tick();
      check("midHold", int'(state), 2);
      enable = 1'b0;
      tick();
      check("abortState", int'(state), 0);
      check("abortMgt", int'(mgtReset), 1);
      check("abortPma", int'(pmaInit), 1);

      // RST_TRAIL held while the MMCM is unlocked
      mmcmNotLocked = 1'b1;
      repeat (3) tick();
      enable = 1'b1;
      tick();
      measure(1, len); measure(2, len);
      check("mmcmTrailEntry", int'(state), 3);
      h = int'($urandom_range(6, 20));
      repeat (h) tick();
      check("mmcmTrailHeld", int'(state), 3);
      mmcmNotLocked = 1'b0;
      measure(3, len);
      check("mmcmTrailLen", h + len, h + SYNC_LAT);
      check("mmcmWaitState", int'(state), 4);

      // restartStrobe coincident with the timeout edge
      repeat (TOUT_N - 1) tick();
      check("preTimeoutState", int'(state), 4);
      restartStrobe = 1'b1; tick(); restartStrobe = 1'b0;
      check("restartWinsState", int'(state), 1);
      check("restartWinsRetry", int'(retryCount), 0);

      // sysReset while UP
      measure(1, len); measure(2, len); measure(3, len);
      channelUp = 1'b1; laneUp = 1'b1;
      waitLink(1'b1, lat);
      check("upAgain", int'(state), 5);
      sysReset = 1'b1;
      tick();
      sysReset = 1'b0;
      check("srstState", int'(state), 0);
      check("srstMgt", int'(mgtReset), 1);
      check("srstPma", int'(pmaInit), 1);
      check("srstLink", int'(linkUp), 0);
      check("srstFault", int'(fault), 0);
      check("srstRetry", int'(retryCount), 0);

`ifdef AURORA_SEQ_ERR_COUNT_EN
      tick();
      measure(1, len); measure(2, len); measure(3, len);
      waitLink(1'b1, lat);
      check("errUp", int'(state), 5);
      for (int i = 0; i < 3; i++) begin
         softErr = 1'b1; tick(); softErr = 1'b0; tick(); tick();
      end
      repeat (3) tick();
      check("errCount3", int'(errCount), 3);
      restartStrobe = 1'b1; tick(); restartStrobe = 1'b0;
      check("errCountCleared", int'(errCount), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
